serial_subtractor_nbits: RTL and testbench

- Multi-cycle subtractor and companion to the ripple-carry adder datapath; computes op1 - op2 - b_in.
- Works a chunk of bits per clock, LSB first, through a registered borrow.
- Trades latency for a short critical path.
- Sits on the same operand buses as the adder; input and output each use a valid/ready handshake.

---
 rtl/serial_subtractor_nbits.sv | 116 +++++++++++
 tb/tb_serial_subtractor_nbits.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_nbits.sv
// Multi-cycle subtractor: op1 - op2 - b_in, chunk_bits per clock, LSB first, valid/ready on both sides.
// Optional macro SUB_SIGNED_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_subtractor_nbits #(
  parameter int n_bits     = 8,
  parameter int chunk_bits = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [n_bits:1]   op1,
  input  logic [n_bits:1]   op2,
  input  logic              b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [n_bits:1]   d,
`ifdef SUB_SIGNED_OVF_EN
  output logic              ovf,
`endif
  output logic              b_out
);

  localparam int n_chunks = n_bits / chunk_bits;
  localparam int cnt_w    = (n_chunks > 1) ? $clog2(n_chunks) : 1;

  generate
    if (n_bits < 2 || chunk_bits < 1 || (n_bits % chunk_bits) != 0) begin : g_bad_cfg
      $error("serial_subtractor_nbits: n_bits must be >= 2 and divisible by chunk_bits");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_next;
  logic [n_bits:1]        a_reg, b_reg;
  logic                   borrow;
  logic [cnt_w-1:0]       cnt;
  logic                   last;
  logic [chunk_bits-1:0]  a_k, b_k, diff_k;
  logic                   borrow_next;
  int                     base;

  // Returns {borrow_out, difference} of a - b - bin over one chunk.
  function automatic logic [chunk_bits:0] sub_chunk(input logic [chunk_bits-1:0] a,
                                                    input logic [chunk_bits-1:0] b,
                                                    input logic bin);
    sub_chunk = {1'b0, a} - {1'b0, b} - {{chunk_bits{1'b0}}, bin};
  endfunction

  always_comb begin
    base = int'(cnt) * chunk_bits + 1;
    a_k  = a_reg[base +: chunk_bits];
    b_k  = b_reg[base +: chunk_bits];
    {borrow_next, diff_k} = sub_chunk(a_k, b_k, borrow);
    last = (cnt == cnt_w'(n_chunks - 1));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: capture on accept, one chunk per RUN edge, hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= op1;
            b_reg  <= op2;
            borrow <= b_in;
            cnt    <= '0;
          end
        end
        RUN: begin
          d[base +: chunk_bits] <= diff_k;
          borrow                <= borrow_next;
          cnt                   <= cnt + cnt_w'(1);
          if (last) begin
            b_out <= borrow_next;
`ifdef SUB_SIGNED_OVF_EN
            // The last chunk holds the sign bit of the final difference.
            ovf   <= (a_reg[n_bits] != b_reg[n_bits]) &&
                     (diff_k[chunk_bits-1] != a_reg[n_bits]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbits.sv
// Scoreboard bench for serial_subtractor_nbits: directed 8-bit vectors plus 4-bit sweeps at three chunk sizes.
module tb_serial_subtractor_nbits;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] d;
    logic       b;
    logic       o;
    int         acc;
    int         lat;
  } exp_t;

  logic       rst_n, in_valid, in_ready, b_in, out_valid, out_ready, b_out;
  logic [7:0] op1, op2, d;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  exp_t q8[$];

  serial_subtractor_nbits #(.n_bits(8), .chunk_bits(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .d(d),
`ifdef SUB_SIGNED_OVF_EN
    .ovf(ovf),
`endif
    .b_out(b_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (got no event, expected one)", nm);
  endtask

  // 8-bit monitor: pops one expectation per completed output handshake.
  initial begin : mon8
    bit   pv;
    int   rise;
    bit   ok;
    exp_t e;
    pv = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk); #2;
      if (out_valid && !pv) rise = cyc;
      pv = out_valid;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_err++;
          $display("FAIL out8_unexpected: got d=%h b_out=%b, expected no output", d, b_out);
        end else begin
          e  = q8.pop_front();
          ok = (d === e.d) && (b_out === e.b) && (rise - e.acc == e.lat);
`ifdef SUB_SIGNED_OVF_EN
          ok = ok && (ovf === e.o);
`endif
          if (!ok) begin
            n_err++;
            $display("FAIL out8: got d=%h b_out=%b lat=%0d, expected d=%h b_out=%b lat=%0d",
                     d, b_out, rise - e.acc, e.d, e.b, e.lat);
`ifdef SUB_SIGNED_OVF_EN
            $display("FAIL out8_ovf: got ovf=%b, expected %b", ovf, e.o);
`endif
          end
        end
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] ed, input logic eb, input logic eo);
    exp_t e;
    int   t;
    t = 0;
    op1 = a; op2 = b; b_in = c; in_valid = 1'b1;
    while (!in_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!in_ready) fail_now("accept8");
    else begin
      e.d = ed; e.b = eb; e.o = eo; e.acc = cyc + 1; e.lat = 4;
      q8.push_back(e);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    op1 = 8'($urandom); op2 = 8'($urandom); b_in = 1'($urandom);
  endtask

  task automatic drain8();
    int t;
    t = 0;
    while (q8.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
    if (q8.size() != 0) fail_now("drain8");
  endtask

  // 4-bit sweep instances with an independent reset.
  logic rst_s_n;
  initial begin
    rst_s_n = 1'b0;
    #22 rst_s_n = 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int CB  = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int LAT = 4 / CB;
    logic       iv, ir, ov, bi, bo, done;
    logic [3:0] a, b, dd;
`ifdef SUB_SIGNED_OVF_EN
    logic       oo;
`endif
    exp_t q[$];

    serial_subtractor_nbits #(.n_bits(4), .chunk_bits(CB)) u_sw (
      .clk(clk), .rst_n(rst_s_n), .in_valid(iv), .in_ready(ir),
      .op1(a), .op2(b), .b_in(bi), .out_valid(ov), .out_ready(1'b1),
      .d(dd),
`ifdef SUB_SIGNED_OVF_EN
      .ovf(oo),
`endif
      .b_out(bo)
    );

    initial begin : drv
      exp_t e;
      int   t;
      done = 1'b0; iv = 1'b0; a = '0; b = '0; bi = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          for (int c = 0; c < 2; c++) begin
            a = x[3:0]; b = y[3:0]; bi = c[0]; iv = 1'b1;
            t = 0;
            while (!ir && t < 20) begin @(negedge clk); #1; t++; end
            if (!ir) fail_now("accept4");
            else begin
              e.d   = 8'((x - y - c) & 15);
              e.b   = (x < y + c);
              e.o   = (a[3] != b[3]) && (e.d[3] != a[3]);
              e.acc = cyc + 1;
              e.lat = LAT;
              q.push_back(e);
            end
            @(negedge clk); #1;
          end
        end
      end
      iv = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
      if (q.size() != 0) fail_now("drain4");
      done = 1'b1;
    end

    initial begin : mon
      bit   pv;
      int   rise;
      bit   ok;
      exp_t e;
      pv = 1'b0;
      rise = 0;
      forever begin
        @(negedge clk); #2;
        if (ov && !pv) rise = cyc;
        pv = ov;
        if (ov) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_err++;
            $display("FAIL out4_cb%0d_unexpected: got d=%h b_out=%b, expected no output", CB, dd, bo);
          end else begin
            e  = q.pop_front();
            ok = (dd === e.d[3:0]) && (bo === e.b) && (rise - e.acc == e.lat);
`ifdef SUB_SIGNED_OVF_EN
            ok = ok && (oo === e.o);
`endif
            if (!ok)  begin
              n_err++;
              $display("FAIL out4_cb%0d: got d=%h b_out=%b lat=%0d, expected d=%h b_out=%b lat=%0d",
                       CB, dd, bo, rise - e.acc, e.d[3:0], e.b, e.lat);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : main
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; b_in = 1'b0;
    @(negedge clk); #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d",         32'(d),         32'd0);
    chk("rst_b_out",     32'(b_out),     32'd0);
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_ovf",       32'(ovf),       32'd0);
`endif
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    send8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    drain8();

    send8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    send8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain8();

    // Backpressure: result held while new operands are offered and ignored.
    out_ready = 1'b0;
    send8(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); #1; t++; end
    if (!out_valid) fail_now("bp_out_valid");
    repeat (5) begin
      in_valid = 1'b1; op1 = 8'h11; op2 = 8'h22; b_in = 1'b1;
      @(negedge clk); #1;
      chk("bp_d",         32'(d),         32'h64);
      chk("bp_b_out",     32'(b_out),     32'd0);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    drain8();
    repeat (6) @(negedge clk);
    #1;

    // Reset during the second RUN cycle of 0xF0 - 0x0F.
    op1 = 8'hF0; op2 = 8'h0F; b_in = 1'b0; in_valid = 1'b1;
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("run_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_d",         32'(d),         32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_b_out",     32'(b_out),     32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    send8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    drain8();

`ifdef SUB_SIGNED_OVF_EN
    send8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    send8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    send8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    drain8();
`endif

    t = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && t < 20000) begin
      @(negedge clk); #1; t++;
    end
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) fail_now("sweep_done");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
